rr_mux4_arbiter: RTL



---
 rtl/rr_mux4_pkg.sv | 28 ++
 rtl/rr_mux4_arbiter_if.sv | 26 ++
 rtl/mux_4_1.sv | 23 ++
 rtl/rr_pick4.sv | 15 +
 rtl/rr_mux4_arbiter.sv | 128 ++++++++++++
 5 files changed

// File: rtl/rr_mux4_pkg.sv
// Shared types and helpers for the four-channel round-robin arbiter.
// The round-robin pick function is also used by rr_pick4.
package rr_mux4_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;
  typedef logic [3:0] ch_mask_t;

  // Returns the first requesting channel, scanning ptr, ptr+1, ... mod 4.
  // Returns 0 when nothing requests; callers qualify the result with |req.
  function automatic ch_idx_t rr_pick(ch_mask_t req, ch_idx_t ptr);
    ch_idx_t idx;
    ch_idx_t pick;
    logic    found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ch_idx_t'(ptr + ch_idx_t'(k));
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Bus between four producer channels, the arbiter and one consumer.
// slave: the arbiter's view. master: the environment's view (producers + consumer).
interface rr_mux4_arbiter_if #(
  parameter int WIDTH = 4
);
  import rr_mux4_pkg::*;

  logic [N_CH-1:0]            in_valid;
  logic [N_CH-1:0][WIDTH-1:0] in_data;
  logic [N_CH-1:0]            in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  ch_idx_t                    out_sel;
  logic                       out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_4_1.sv
// 4-bit 4:1 data multiplexer.
module mux_4_1 (
  input  logic [1:0] sel,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] y
);

  // Select one of four words.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotate-priority encoder: picks the first valid channel
// starting at the round-robin pointer.
module rr_pick4
  import rr_mux4_pkg::*;
(
  input  ch_mask_t req,
  input  ch_idx_t  ptr,
  output ch_idx_t  gnt,
  output logic     gnt_vld
);

  assign gnt     = rr_pick(req, ptr);
  assign gnt_vld = |req;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four valid/ready channels feeding a one-entry
// registered output stage. The grant selects the word through mux_4_1.
// Optional macro RR_ARB_STICKY_EN: a granted channel keeps the grant for up
// to MAX_BURST consecutive beats while it stays valid.
module rr_mux4_arbiter
  import rr_mux4_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  rr_mux4_arbiter_if.slave bus
);

  if (WIDTH != 4) begin : g_width_chk
    $error("rr_mux4_arbiter: WIDTH must be 4 while the datapath uses mux_4_1");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_chk
    $error("rr_mux4_arbiter: MAX_BURST must be in 1..15");
  end

  ch_idx_t          ptr_q;
  ch_idx_t          ptr_d;
  ch_idx_t          gnt;
  logic             gnt_vld;
  logic             space;
  logic             xfer;
  logic [N_CH-1:0]  ready;
  logic [WIDTH-1:0] mux_y;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  ch_idx_t          out_sel_q;

  rr_pick4 u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  mux_4_1 u_mux (
    .sel (gnt),
    .d0  (bus.in_data[0]),
    .d1  (bus.in_data[1]),
    .d2  (bus.in_data[2]),
    .d3  (bus.in_data[3]),
    .y   (mux_y)
  );

  // The output slot is free when empty or being drained this cycle; nothing
  // is accepted while reset is held so no producer loses a word.
  assign space = ~out_valid_q | bus.out_ready;
  assign xfer  = gnt_vld & space & ~rst;

  // One-hot ready towards the granted channel only.
  always_comb begin
    ready = '0;
    if (xfer) ready[gnt] = 1'b1;
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef RR_ARB_STICKY_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [3:0] burst_q;
  logic [3:0] burst_d;
  logic [3:0] burst_base;

  // Keep the pointer on the granted channel until its burst is used up; a
  // grant to a different channel starts a fresh burst count.
  always_comb begin
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    burst_base = (gnt == ptr_q) ? burst_q : 4'd0;
    if (xfer) begin
      if (burst_base < BURST_LAST) begin
        ptr_d   = gnt;
        burst_d = burst_base + 4'd1;
      end else begin
        ptr_d   = ch_idx_t'(gnt + 2'd1);
        burst_d = 4'd0;
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (rst) burst_q <= 4'd0;
    else     burst_q <= burst_d;
  end
`else
  // Pointer moves just past the channel that was served.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = ch_idx_t'(gnt + 2'd1);
  end
`endif

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // One-entry output stage: load on accept, clear valid on a bare drain,
  // hold everything on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_y;
      out_sel_q   <= gnt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
